// File: rtl/capture_pkg.sv
// Shared definitions for the capture/trigger buffer: FSM state encoding and
// trigger mode constants.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTFILL  = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FREE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port frame RAM: synchronous write, registered synchronous read.
// The read register is reset so the block output is 0 out of reset.
module sample_ram #(
    parameter  int DEPTH = 256,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Write port: array has no reset, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one-cycle registered read, holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_trigger_buffer.sv
// Capture/trigger buffer: scales ADC samples to display width, decimates,
// and records one DEPTH-sample frame around an edge trigger into a circular
// RAM, then lets the VGA reader pop it oldest-first.
// Read handshake: rd_req pops one sample only while finished=1; the sample
// appears on data_out with data_valid=1 exactly one cycle later.
module capture_trigger_buffer
    import capture_pkg::*;
#(
    parameter  int ADC_W   = 14,
    parameter  int OUT_W   = 8,
    parameter  int DEPTH   = 256,
    parameter  int DECIM_W = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [ADC_W-1:0]   data_in,
    input  logic               arm,
    input  logic [1:0]         mode,
    input  logic               single,
    input  logic [OUT_W-1:0]   trig_level,
    input  logic [AW-1:0]      pretrig,
    input  logic [DECIM_W-1:0] decim,
    input  logic               rd_req,
    output logic [OUT_W-1:0]   data_out,
    output logic               data_valid,
    output logic               finished,
    output logic               overrun,
    output state_t             dbg_state
);

    state_t             r_state;
    logic [1:0]         r_mode;
    logic               r_single;
    logic [OUT_W-1:0]   r_level;
    logic [AW-1:0]      r_pretrig;
    logic [DECIM_W-1:0] r_decim;
    logic [DECIM_W-1:0] r_dec_cnt;
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [AW-1:0]      r_taddr;
    logic [AW-1:0]      r_cnt;
    logic [AW-1:0]      r_rd_cnt;
    logic [OUT_W-1:0]   r_prev;
    logic               r_prev_ok;
    logic               r_finished;
    logic               r_overrun;
    logic               r_data_valid;

    logic [OUT_W-1:0]   w_s;
    logic               w_data_unused;
    logic               w_accept;
    logic               w_capturing;
    logic               w_we;
    logic               w_rd;
    logic               w_last_rd;
    logic               w_arm_go;
    logic               w_trig;
    logic [AW-1:0]      w_post;
    logic [OUT_W-1:0]   w_ram_q;

    // Truncating scale: keep the top OUT_W bits; the dropped LSBs are intentional.
    assign w_s           = data_in[ADC_W-1 -: OUT_W];
    assign w_data_unused = ^data_in;

    assign w_accept    = sample_valid && (r_dec_cnt == '0);
    assign w_capturing = (r_state == PREFILL) || (r_state == WAIT_TRIG) || (r_state == POSTFILL);
    assign w_we        = w_accept && w_capturing;
    assign w_rd        = rd_req && (r_state == HOLD);
    assign w_last_rd   = w_rd && (r_rd_cnt == AW'(DEPTH - 1));
    // Fresh arm from IDLE, or automatic re-arm when the last sample of a frame is read.
    assign w_arm_go    = ((r_state == IDLE) && arm) || (w_last_rd && !r_single);
    assign w_post      = AW'(DEPTH - 1) - r_pretrig;

    // Trigger condition on the current accepted sample; reserved mode behaves as free-run.
    always_comb begin
        w_trig = 1'b0;
        unique case (r_mode)
            MODE_RISE: w_trig = r_prev_ok && (r_prev < r_level) && (w_s >= r_level);
            MODE_FALL: w_trig = r_prev_ok && (r_prev >= r_level) && (w_s < r_level);
            default:   w_trig = 1'b1;
        endcase
    end

    // Decimation counter: runs on every valid sample, cleared by an explicit arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec_cnt <= '0;
        end else if ((r_state == IDLE) && arm) begin
            r_dec_cnt <= '0;
        end else if (sample_valid) begin
            r_dec_cnt <= (r_dec_cnt == '0) ? r_decim : r_dec_cnt - 1'b1;
        end
    end

    // Circular write pointer advances on every sample written to the RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
        end else if (w_we) begin
            r_wp <= r_wp + 1'b1;
        end
    end

    // Capture FSM with config latch, trigger history, readout pointer and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_mode       <= MODE_FREE;
            r_single     <= 1'b0;
            r_level      <= '0;
            r_pretrig    <= '0;
            r_decim      <= '0;
            r_rp         <= '0;
            r_taddr      <= '0;
            r_cnt        <= '0;
            r_rd_cnt     <= '0;
            r_prev       <= '0;
            r_prev_ok    <= 1'b0;
            r_finished   <= 1'b0;
            r_overrun    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd;
            if (w_rd) begin
                r_rp     <= r_rp + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_accept && (r_state == HOLD)) begin
                r_overrun <= 1'b1;
            end
            if (w_accept && ((r_state == PREFILL) || (r_state == WAIT_TRIG))) begin
                r_prev    <= w_s;
                r_prev_ok <= 1'b1;
            end

            if (w_arm_go) begin
                r_mode     <= mode;
                r_single   <= single;
                r_level    <= trig_level;
                r_pretrig  <= pretrig;
                r_decim    <= decim;
                r_overrun  <= 1'b0;
                r_prev_ok  <= 1'b0;
                r_cnt      <= '0;
                r_rd_cnt   <= '0;
                r_finished <= 1'b0;
                r_state    <= (pretrig == '0) ? WAIT_TRIG : PREFILL;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_prev_ok <= 1'b0;
                    end
                    PREFILL: begin
                        if (w_accept) begin
                            if (r_cnt == r_pretrig - 1'b1) begin
                                r_cnt   <= '0;
                                r_state <= WAIT_TRIG;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (w_accept && w_trig) begin
                            r_taddr <= r_wp;
                            r_cnt   <= '0;
                            if (w_post == '0) begin
                                r_rp       <= r_wp - r_pretrig;
                                r_rd_cnt   <= '0;
                                r_finished <= 1'b1;
                                r_state    <= HOLD;
                            end else begin
                                r_state <= POSTFILL;
                            end
                        end
                    end
                    POSTFILL: begin
                        if (w_accept) begin
                            if (r_cnt == w_post - 1'b1) begin
                                r_rp       <= r_taddr - r_pretrig;
                                r_rd_cnt   <= '0;
                                r_finished <= 1'b1;
                                r_state    <= HOLD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (w_last_rd) begin
                            r_finished <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    sample_ram #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we),
        .i_waddr (r_wp),
        .i_wdata (w_s),
        .i_re    (w_rd),
        .i_raddr (r_rp),
        .o_rdata (w_ram_q)
    );

    assign data_out   = w_ram_q;
    assign data_valid = r_data_valid;
    assign finished   = r_finished;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_capture_trigger_buffer.sv
// Bench for capture_trigger_buffer at DEPTH=16: directed frame table,
// hand-written corner sequences and randomized frames against a queue model.
module tb_capture_trigger_buffer;
    import capture_pkg::*;

    localparam int ADC_W   = 14;
    localparam int OUT_W   = 8;
    localparam int DEPTH   = 16;
    localparam int DECIM_W = 8;
    localparam int AW      = 4;

    logic               clk          = 1'b0;
    logic               reset        = 1'b0;
    logic               sample_valid = 1'b0;
    logic [ADC_W-1:0]   data_in      = '0;
    logic               arm          = 1'b0;
    logic [1:0]         mode         = 2'b00;
    logic               single       = 1'b1;
    logic [OUT_W-1:0]   trig_level   = '0;
    logic [AW-1:0]      pretrig      = '0;
    logic [DECIM_W-1:0] decim        = '0;
    logic               rd_req       = 1'b0;
    logic [OUT_W-1:0]   data_out;
    logic               data_valid;
    logic               finished;
    logic               overrun;
    state_t             dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [OUT_W-1:0] stim_q[$];
    logic [OUT_W-1:0] acc_q[$];
    logic [OUT_W-1:0] exp_q[$];
    bit exp_found;
    bit exp_over;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] lvl;
        int         pt;
        int         dc;
        int         start;
        int         len;
        logic [7:0] exp_first;
        int         exp_step;
        logic       exp_over;
    } vec_t;
    vec_t vecs[5];

    capture_trigger_buffer #(
        .ADC_W   (ADC_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .DECIM_W (DECIM_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .arm          (arm),
        .mode         (mode),
        .single       (single),
        .trig_level   (trig_level),
        .pretrig      (pretrig),
        .decim        (decim),
        .rd_req       (rd_req),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .finished     (finished),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [7:0] lvl, input logic [3:0] pt,
                          input logic [7:0] dc, input logic sgl, input bit scramble);
        mode = m; trig_level = lvl; pretrig = pt; decim = dc; single = sgl;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm state", 32'(dbg_state), (pt == 4'd0) ? 32'(WAIT_TRIG) : 32'(PREFILL));
        check("arm overrun clear", 32'(overrun), 32'(0));
        check("arm finished", 32'(finished), 32'(0));
        if (scramble) begin
            mode = 2'($urandom_range(0, 3));
            trig_level = 8'($urandom_range(0, 255));
            pretrig = 4'($urandom_range(0, 15));
            decim = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic drive_stream(input bit gaps);
        foreach (stim_q[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                sample_valid = 1'b0;
                data_in = 14'($urandom_range(0, 16383));
                tick();
            end
            sample_valid = 1'b1;
            data_in = {stim_q[i], 6'($urandom_range(0, 63))};
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic read_frame(input bit gaps, input string tag);
        int issued = 0;
        int guard = 0;
        bit req;
        check({tag, " finished before read"}, 32'(finished), 32'(1));
        while (issued < DEPTH && guard < 400) begin
            req = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            rd_req = req;
            tick();
            guard++;
            check({tag, " data_valid"}, 32'(data_valid), 32'(req));
            if (req) begin
                check({tag, " data_out"}, 32'(data_out), 32'(exp_q[issued]));
                issued++;
            end
        end
        rd_req = 1'b0;
        check({tag, " finished after read"}, 32'(finished), 32'(0));
    endtask

    // Frame model: accepted samples by decimation index, first qualifying trigger,
    // and the DEPTH samples starting pretrig before it.
    task automatic build_model(input logic [1:0] m, input logic [7:0] lvl, input int pt, input int dc);
        int t;
        bit hit;
        acc_q.delete();
        exp_q.delete();
        t = -1;
        foreach (stim_q[j]) if ((j % (dc + 1)) == 0) acc_q.push_back(stim_q[j]);
        for (int i = pt; i < acc_q.size(); i++) begin
            case (m)
                2'b01:   hit = (i > 0) && (acc_q[i-1] < lvl) && (acc_q[i] >= lvl);
                2'b10:   hit = (i > 0) && (acc_q[i-1] >= lvl) && (acc_q[i] < lvl);
                default: hit = 1'b1;
            endcase
            if (hit) begin
                t = i;
                break;
            end
        end
        exp_found = (t >= 0) && ((t - pt + DEPTH) <= acc_q.size());
        exp_over  = exp_found && (acc_q.size() > (t - pt + DEPTH));
        if (exp_found) for (int k = 0; k < DEPTH; k++) exp_q.push_back(acc_q[t - pt + k]);
    endtask

    task automatic run_vec(input int v);
        do_arm(vecs[v].mode, vecs[v].lvl, 4'(vecs[v].pt), 8'(vecs[v].dc), 1'b1, 1'b1);
        stim_q.delete();
        for (int i = 0; i < vecs[v].len; i++) stim_q.push_back(8'(vecs[v].start + i));
        drive_stream(1'b0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(int'(vecs[v].exp_first) + i * vecs[v].exp_step));
        check($sformatf("vec%0d state hold", v), 32'(dbg_state), 32'(HOLD));
        check($sformatf("vec%0d overrun", v), 32'(overrun), 32'(vecs[v].exp_over));
        read_frame(1'b0, $sformatf("vec%0d", v));
        check($sformatf("vec%0d state idle", v), 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        vecs[0] = '{2'b01, 8'h80, 4,  0, 100, 101, 8'd124, 1, 1'b1};
        vecs[1] = '{2'b00, 8'h00, 0,  2, 0,   48,  8'd0,   3, 1'b0};
        vecs[2] = '{2'b11, 8'h00, 5,  0, 10,  16,  8'd10,  1, 1'b0};
        vecs[3] = '{2'b01, 8'h80, 3,  1, 120, 60,  8'd122, 2, 1'b1};
        vecs[4] = '{2'b01, 8'h80, 15, 0, 100, 29,  8'd113, 1, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", 32'(data_out), 32'(0));
        check("reset data_valid", 32'(data_valid), 32'(0));
        check("reset finished", 32'(finished), 32'(0));
        check("reset overrun", 32'(overrun), 32'(0));
        check("reset state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        rd_req = 1'b1;
        tick();
        check("idle rd_req ignored", 32'(data_valid), 32'(0));
        rd_req = 1'b0;

        // Directed frame table
        for (int v = 0; v < 5; v++) run_vec(v);

        // Falling edge with pretrig 2
        do_arm(2'b10, 8'h40, 4'd2, 8'd0, 1'b1, 1'b1);
        stim_q.delete();
        stim_q.push_back(8'h50);
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'h41 - i));
        drive_stream(1'b0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h41 - i));
        check("fall overrun", 32'(overrun), 32'(0));
        read_frame(1'b0, "fall");

        // Auto re-arm
        do_arm(2'b01, 8'h80, 4'd4, 8'd0, 1'b0, 1'b0);
        stim_q.delete();
        for (int i = 0; i < 60; i++) stim_q.push_back(8'(100 + i));
        drive_stream(1'b0);
        check("rearm overrun set", 32'(overrun), 32'(1));
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(124 + i));
        single = 1'b1;
        read_frame(1'b0, "rearm1");
        check("rearm state", 32'(dbg_state), 32'(PREFILL));
        check("rearm overrun cleared", 32'(overrun), 32'(0));
        stim_q.delete();
        for (int i = 0; i < 40; i++) stim_q.push_back(8'(8'h70 + i));
        drive_stream(1'b0);
        check("rearm2 overrun", 32'(overrun), 32'(1));
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h7C + i));
        read_frame(1'b0, "rearm2");
        check("rearm2 state idle", 32'(dbg_state), 32'(IDLE));
        check("rearm2 overrun sticky", 32'(overrun), 32'(1));

        // Reset mid-POSTFILL
        do_arm(2'b01, 8'h80, 4'd4, 8'd0, 1'b1, 1'b0);
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(120 + i));
        drive_stream(1'b0);
        check("postfill state", 32'(dbg_state), 32'(POSTFILL));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort data_out", 32'(data_out), 32'(0));
        check("abort data_valid", 32'(data_valid), 32'(0));
        check("abort finished", 32'(finished), 32'(0));
        check("abort state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        rd_req = 1'b1;
        repeat (3) begin
            tick();
            check("post-reset rd_req", 32'(data_valid), 32'(0));
        end
        rd_req = 1'b0;
        run_vec(0);

        // rd_req in WAIT_TRIG, arm in HOLD
        do_arm(2'b01, 8'h80, 4'd2, 8'd0, 1'b1, 1'b0);
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back(8'h10);
        drive_stream(1'b0);
        rd_req = 1'b1;
        repeat (3) begin
            tick();
            check("wait rd_req data_valid", 32'(data_valid), 32'(0));
            check("wait rd_req state", 32'(dbg_state), 32'(WAIT_TRIG));
        end
        rd_req = 1'b0;
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'h7E + i));
        drive_stream(1'b0);
        check("hold reached", 32'(dbg_state), 32'(HOLD));
        pretrig = 4'd0;
        mode = 2'b00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("hold arm state", 32'(dbg_state), 32'(HOLD));
        check("hold arm finished", 32'(finished), 32'(1));
        check("hold arm data_valid", 32'(data_valid), 32'(0));
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h7E + i));
        read_frame(1'b0, "holdarm");

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            logic [1:0] m;
            logic [7:0] lvl;
            int pt;
            int dc;
            int n;
            m = 2'($urandom_range(0, 3));
            lvl = 8'($urandom_range(1, 255));
            pt = $urandom_range(0, 15);
            dc = $urandom_range(0, 3);
            do_arm(m, lvl, 4'(pt), 8'(dc), 1'b1, 1'b1);
            stim_q.delete();
            n = $urandom_range(40, 120);
            for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom_range(0, 255)));
            drive_stream(1'b1);
            build_model(m, lvl, pt, dc);
            check("rand finished", 32'(finished), 32'(exp_found));
            if (exp_found) begin
                check("rand overrun", 32'(overrun), 32'(exp_over));
                read_frame(1'b1, "rand");
                check("rand state idle", 32'(dbg_state), 32'(IDLE));
            end else begin
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
